// File: rtl/io_key_sw_ctrl.sv
// io_key_sw_ctrl: memory-mapped KEY/SW input controller on the processor data bus.
//   Synchronises (two FFs) and debounces the board KEY[3:0] (active-low pins) and SW[9:0]
//   (active-high pins). Each group debounces as a whole word and exposes a DATA register
//   and a CTRL register (bit0 Ready, bit2 Overrun, bit8 IE). Ready is sticky and clears on
//   a DATA load or a CTRL write with dIn[0]=0. Overrun is sticky and clears on a CTRL
//   write with dIn[2]=0.
// Build option: define IO_KEY_SW_IRQ_EN to implement the IE bits and a registered irq.
//   Without it, irq is tied low and CTRL bit8 reads 0 (writes ignored).
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active-low
//   addr   bus address            wrtEn  store strobe        rdEn  load strobe
//   dIn    store data             key    raw KEY pins        sw    raw SW pins
//   dOut   read data (0 when sel=0, combinational)
//   sel    addr hits one of the four registers
//   irq    interrupt request
module io_key_sw_ctrl #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
    parameter int unsigned      DEBOUNCE_CYCLES = 10000,
    parameter int unsigned      CNT_BITS        = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wrtEn,
    input  logic             rdEn,
    input  logic [DBITS-1:0] dIn,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic [DBITS-1:0] dOut,
    output logic             sel,
    output logic             irq
);

    localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    // Synchronisers
    logic [3:0] keyMetaQ, keySyncQ;
    logic [9:0] swMetaQ, swSyncQ;
    logic [3:0] keyPressed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyMetaQ <= 4'hF;
            keySyncQ <= 4'hF;
            swMetaQ  <= '0;
            swSyncQ  <= '0;
        end else begin
            keyMetaQ <= key;
            keySyncQ <= keyMetaQ;
            swMetaQ  <= sw;
            swSyncQ  <= swMetaQ;
        end
    end

    // Pins are active-low; everything downstream sees 1 = pressed.
    assign keyPressed = ~keySyncQ;

    // Debounce: a whole-group candidate must hold for DEBOUNCE_CYCLES further cycles.
    logic [3:0]          keyCandQ, keyCandD, keyDebQ, keyDebD;
    logic [CNT_BITS-1:0] keyCntQ, keyCntD;
    logic                keyEvent;
    logic [9:0]          swCandQ, swCandD, swDebQ, swDebD;
    logic [CNT_BITS-1:0] swCntQ, swCntD;
    logic                swEvent;

    always_comb begin
        keyCandD = keyCandQ;
        keyCntD  = keyCntQ;
        keyDebD  = keyDebQ;
        keyEvent = 1'b0;
        if (keyPressed != keyCandQ) begin
            keyCandD = keyPressed;
            keyCntD  = '0;
        end else if (keyCandQ != keyDebQ) begin
            if (keyCntQ == CntMax) begin
                keyDebD  = keyCandQ;
                keyCntD  = '0;
                keyEvent = 1'b1;
            end else begin
                keyCntD = keyCntQ + CNT_BITS'(1);
            end
        end else begin
            keyCntD = '0;
        end
    end

    always_comb begin
        swCandD = swCandQ;
        swCntD  = swCntQ;
        swDebD  = swDebQ;
        swEvent = 1'b0;
        if (swSyncQ != swCandQ) begin
            swCandD = swSyncQ;
            swCntD  = '0;
        end else if (swCandQ != swDebQ) begin
            if (swCntQ == CntMax) begin
                swDebD  = swCandQ;
                swCntD  = '0;
                swEvent = 1'b1;
            end else begin
                swCntD = swCntQ + CNT_BITS'(1);
            end
        end else begin
            swCntD = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyCandQ <= '0;
            keyCntQ  <= '0;
            keyDebQ  <= '0;
            swCandQ  <= '0;
            swCntQ   <= '0;
            swDebQ   <= '0;
        end else begin
            keyCandQ <= keyCandD;
            keyCntQ  <= keyCntD;
            keyDebQ  <= keyDebD;
            swCandQ  <= swCandD;
            swCntQ   <= swCntD;
            swDebQ   <= swDebD;
        end
    end

    // Bus decode and status flags
    logic kDataRd, kCtrlWr, kReadyClr, kOverrunClr;
    logic sDataRd, sCtrlWr, sReadyClr, sOverrunClr;
    logic kReadyQ, kReadyD, kOverrunQ, kOverrunD;
    logic sReadyQ, sReadyD, sOverrunQ, sOverrunD;
    logic kIeQ, sIeQ;
    logic unusedBits;

    assign kDataRd     = rdEn && (addr == ADDR_KEY);
    assign kCtrlWr     = wrtEn && (addr == ADDR_KCTRL);
    assign kReadyClr   = kDataRd || (kCtrlWr && !dIn[0]);
    assign kOverrunClr = kCtrlWr && !dIn[2];
    assign sDataRd     = rdEn && (addr == ADDR_SW);
    assign sCtrlWr     = wrtEn && (addr == ADDR_SCTRL);
    assign sReadyClr   = sDataRd || (sCtrlWr && !dIn[0]);
    assign sOverrunClr = sCtrlWr && !dIn[2];

    // An event beats a same-cycle Ready clear; an Overrun set beats a same-cycle clear
    // so a lost sample is never silently forgotten.
    always_comb begin
        kReadyD   = keyEvent || (kReadyQ && !kReadyClr);
        kOverrunD = (keyEvent && kReadyQ && !kReadyClr) || (kOverrunQ && !kOverrunClr);
        sReadyD   = swEvent || (sReadyQ && !sReadyClr);
        sOverrunD = (swEvent && sReadyQ && !sReadyClr) || (sOverrunQ && !sOverrunClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kReadyQ   <= 1'b0;
            kOverrunQ <= 1'b0;
            sReadyQ   <= 1'b0;
            sOverrunQ <= 1'b0;
        end else begin
            kReadyQ   <= kReadyD;
            kOverrunQ <= kOverrunD;
            sReadyQ   <= sReadyD;
            sOverrunQ <= sOverrunD;
        end
    end

`ifdef IO_KEY_SW_IRQ_EN
    logic irqQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kIeQ <= 1'b0;
            sIeQ <= 1'b0;
            irqQ <= 1'b0;
        end else begin
            if (kCtrlWr) kIeQ <= dIn[8];
            if (sCtrlWr) sIeQ <= dIn[8];
            irqQ <= (kReadyQ && kIeQ) || (sReadyQ && sIeQ);
        end
    end

    assign irq        = irqQ;
    assign unusedBits = ^{dIn[DBITS-1:9], dIn[7:3], dIn[1]};
`else
    assign kIeQ       = 1'b0;
    assign sIeQ       = 1'b0;
    assign irq        = 1'b0;
    assign unusedBits = ^{dIn[DBITS-1:3], dIn[1]};
`endif

    // Read mux
    function automatic logic [DBITS-1:0] ctrlWord(input logic rdy, input logic ovr,
                                                  input logic ie);
        logic [DBITS-1:0] w;
        w    = '0;
        w[0] = rdy;
        w[2] = ovr;
        w[8] = ie;
        return w;
    endfunction

    always_comb begin
        dOut = '0;
        sel  = 1'b1;
        if (addr == ADDR_KEY) begin
            dOut = DBITS'(keyDebQ);
        end else if (addr == ADDR_KCTRL) begin
            dOut = ctrlWord(kReadyQ, kOverrunQ, kIeQ);
        end else if (addr == ADDR_SW) begin
            dOut = DBITS'(swDebQ);
        end else if (addr == ADDR_SCTRL) begin
            dOut = ctrlWord(sReadyQ, sOverrunQ, sIeQ);
        end else begin
            sel = 1'b0;
        end
    end

endmodule

// File: tb/tb_io_key_sw_ctrl.sv
// Bench for io_key_sw_ctrl with DEBOUNCE_CYCLES=4: register-map table, hand-written
// debounce/flag sequences and a randomized run against a run-length reference model.
`timescale 1ns/1ps
module tb_io_key_sw_ctrl;

    localparam int unsigned DC  = 4;
    localparam logic [31:0] AK  = 32'hF0000010;
    localparam logic [31:0] AKC = 32'hF0000110;
    localparam logic [31:0] AS  = 32'hF0000014;
    localparam logic [31:0] ASC = 32'hF0000114;
`ifdef IO_KEY_SW_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [31:0] IEV = IRQ ? 32'h100 : 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, dIn, dOut;
    logic        wrtEn, rdEn, sel, irq;
    logic [3:0]  key;
    logic [9:0]  sw;

    io_key_sw_ctrl #(
        .DBITS(32), .DEBOUNCE_CYCLES(DC), .CNT_BITS(3)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .rdEn(rdEn), .dIn(dIn),
        .key(key), .sw(sw), .dOut(dOut), .sel(sel), .irq(irq)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: debounced value follows the synchronised input once that input
    // has held one value for DC+1 consecutive clock edges.
    logic [3:0] mKDeb, kLast;
    logic [9:0] mSDeb, sLast;
    bit         mKRdy, mKOvr, mKIe, mSRdy, mSOvr, mSIe, mIrq;
    logic [3:0] kHist[$];
    logic [9:0] sHist[$];
    int         kRun, sRun;

    task automatic modelReset();
        mKDeb = '0; mSDeb = '0; kLast = '0; sLast = '0;
        mKRdy = 0; mKOvr = 0; mKIe = 0; mSRdy = 0; mSOvr = 0; mSIe = 0; mIrq = 0;
        kHist = {}; kHist.push_back(4'h0); kHist.push_back(4'h0);
        sHist = {}; sHist.push_back(10'h0); sHist.push_back(10'h0);
        kRun = 1; sRun = 1;
    endtask

    function automatic logic [31:0] ctrlVal(bit r, bit o, bit ie);
        return {23'b0, ie, 5'b0, o, 1'b0, r};
    endfunction

    function automatic logic [31:0] mRead(logic [31:0] a);
        case (a)
            AK:      return {28'b0, mKDeb};
            AKC:     return ctrlVal(mKRdy, mKOvr, mKIe);
            AS:      return {22'b0, mSDeb};
            ASC:     return ctrlVal(mSRdy, mSOvr, mSIe);
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: optionally compare outputs with the model, then advance the model.
    task automatic tick(input bit doCheck);
        logic [3:0] ks;
        logic [9:0] ss;
        bit kEv, sEv, kClr, sClr, kCw, sCw;
        bit nKRdy, nKOvr, nKIe, nSRdy, nSOvr, nSIe, nIrq;
        if (doCheck) begin
            #1;
            check("rand dOut", dOut, mRead(addr));
            check("rand sel", {31'b0, sel}, {31'b0, (addr == AK || addr == AKC ||
                                                      addr == AS || addr == ASC)});
            check("rand irq", {31'b0, irq}, {31'b0, mIrq});
        end
        ks = kHist.pop_front(); kHist.push_back(~key);
        ss = sHist.pop_front(); sHist.push_back(sw);
        if (ks === kLast) kRun++; else begin kRun = 1; kLast = ks; end
        if (ss === sLast) sRun++; else begin sRun = 1; sLast = ss; end
        kEv  = (kRun == DC + 1) && (ks != mKDeb);
        sEv  = (sRun == DC + 1) && (ss != mSDeb);
        kCw  = wrtEn && addr == AKC;
        sCw  = wrtEn && addr == ASC;
        kClr = (rdEn && addr == AK) || (kCw && !dIn[0]);
        sClr = (rdEn && addr == AS) || (sCw && !dIn[0]);
        nKRdy = kEv ? 1'b1 : (kClr ? 1'b0 : mKRdy);
        nSRdy = sEv ? 1'b1 : (sClr ? 1'b0 : mSRdy);
        nKOvr = (kCw && !dIn[2]) ? 1'b0 : mKOvr;
        if (kEv && mKRdy && !kClr) nKOvr = 1'b1;
        nSOvr = (sCw && !dIn[2]) ? 1'b0 : mSOvr;
        if (sEv && mSRdy && !sClr) nSOvr = 1'b1;
        nKIe = (IRQ && kCw) ? dIn[8] : mKIe;
        nSIe = (IRQ && sCw) ? dIn[8] : mSIe;
        nIrq = IRQ && ((mKRdy && mKIe) || (mSRdy && mSIe));
        @(posedge clk);
        #1;
        if (kEv) mKDeb = ks;
        if (sEv) mSDeb = ss;
        mKRdy = nKRdy; mKOvr = nKOvr; mKIe = nKIe;
        mSRdy = nSRdy; mSOvr = nSOvr; mSIe = nSIe; mIrq = nIrq;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(0);
    endtask

    task automatic expectReg(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rdEn = 1'b0; wrtEn = 1'b0;
        #1;
        check(name, dOut, exp);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        addr = 32'h0; rdEn = 1'b0; wrtEn = 1'b0; dIn = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        modelReset();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rdEn;
        logic        wrtEn;
        logic [31:0] dIn;
        logic [31:0] expDout;
        logic        expSel;
    } vec_t;

    vec_t tbl[$];

    initial begin
        key = 4'hF; sw = 10'h0;
        applyReset();

        // 1. Reset state
        expectReg("rst KDATA", AK, 32'h0);
        expectReg("rst KCTRL", AKC, 32'h0);
        expectReg("rst SDATA", AS, 32'h0);
        expectReg("rst SCTRL", ASC, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);

        // Register map, write masking and side-effect-free accesses
        tbl.push_back('{AK, 0, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{AKC, 0, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{AS, 0, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{ASC, 0, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{32'hF0000018, 1, 0, 32'h0, 32'h0, 0});
        tbl.push_back('{32'h00000010, 0, 0, 32'h0, 32'h0, 0});
        tbl.push_back('{32'hF0000111, 0, 0, 32'h0, 32'h0, 0});
        tbl.push_back('{AKC, 0, 1, 32'h105, 32'h0, 1});
        tbl.push_back('{AKC, 1, 0, 32'h0, IEV, 1});
        tbl.push_back('{AK, 0, 1, 32'hFFFFFFFF, 32'h0, 1});
        tbl.push_back('{AK, 0, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{ASC, 0, 1, 32'hFFFFFFFF, 32'h0, 1});
        tbl.push_back('{ASC, 0, 0, 32'h0, IEV, 1});
        tbl.push_back('{AS, 0, 1, 32'h3FF, 32'h0, 1});
        tbl.push_back('{ASC, 0, 1, 32'h0, IEV, 1});
        tbl.push_back('{ASC, 1, 0, 32'h0, 32'h0, 1});
        tbl.push_back('{AKC, 0, 1, 32'h0, IEV, 1});
        tbl.push_back('{AKC, 0, 0, 32'h0, 32'h0, 1});
        foreach (tbl[i]) begin
            addr = tbl[i].addr; rdEn = tbl[i].rdEn; wrtEn = tbl[i].wrtEn; dIn = tbl[i].dIn;
            #1;
            check($sformatf("tbl%0d dOut", i), dOut, tbl[i].expDout);
            check($sformatf("tbl%0d sel", i), {31'b0, sel}, {31'b0, tbl[i].expSel});
            tick(0);
        end
        rdEn = 1'b0; wrtEn = 1'b0;

        // 2. Key press latency and read-to-clear
        key = 4'hE; addr = AK;
        for (int e = 1; e <= 7; e++) begin
            tick(0);
            expectReg($sformatf("press edge%0d", e), AK, (e == 7) ? 32'h1 : 32'h0);
        end
        expectReg("press KCTRL", AKC, 32'h1);
        addr = AK; rdEn = 1'b1; #1;
        check("LW KDATA", dOut, 32'h1);
        tick(0);
        expectReg("KCTRL after LW", AKC, 32'h0);
        expectReg("KDATA after LW", AK, 32'h1);

        // 5. Event coinciding with a DATA load while Ready is already set
        key = 4'hF;
        ticks(7);
        expectReg("release KDATA", AK, 32'h0);
        expectReg("release KCTRL", AKC, 32'h1);
        key = 4'hE;
        ticks(6);
        addr = AK; rdEn = 1'b1; #1;
        check("coincident read old", dOut, 32'h0);
        tick(0);
        expectReg("coincident KCTRL", AKC, 32'h1);
        expectReg("coincident KDATA", AK, 32'h1);

        // 3. Switch bounce restarts the count
        sw = 10'h1; tick(0); tick(0); expectReg("bounce a", AS, 32'h0);
        sw = 10'h0; tick(0); tick(0); expectReg("bounce b", AS, 32'h0);
        sw = 10'h1;
        for (int e = 1; e <= 7; e++) begin
            tick(0);
            expectReg($sformatf("bounce edge%0d", e), AS, (e == 7) ? 32'h1 : 32'h0);
        end
        expectReg("bounce SCTRL", ASC, 32'h1);

        // 4. Overrun and CTRL write clear
        key = 4'hF; sw = 10'h0;
        applyReset();
        sw = 10'h001; ticks(7);
        expectReg("ovr SDATA1", AS, 32'h1);
        expectReg("ovr SCTRL1", ASC, 32'h1);
        sw = 10'h003; ticks(7);
        expectReg("ovr SDATA3", AS, 32'h3);
        expectReg("ovr SCTRL", ASC, 32'h5);
        addr = ASC; wrtEn = 1'b1; dIn = 32'h0;
        tick(0);
        expectReg("ovr cleared", ASC, 32'h0);
        expectReg("ovr SDATA kept", AS, 32'h3);

        // Reset during a debounce count discards it
        key = 4'hE; ticks(4);
        reset = 1'b0; #1;
        expectReg("in reset KDATA", AK, 32'h0);
        expectReg("in reset SDATA", AS, 32'h0);
        applyReset();
        for (int e = 1; e <= 7; e++) begin
            tick(0);
            expectReg($sformatf("post-rst edge%0d", e), AK, (e == 7) ? 32'h1 : 32'h0);
        end

`ifdef IO_KEY_SW_IRQ_EN
        // 6. Interrupt path
        key = 4'hF;
        applyReset();
        addr = AKC; wrtEn = 1'b1; dIn = 32'h100;
        tick(0);
        expectReg("IE set", AKC, 32'h100);
        key = 4'hE; ticks(7);
        expectReg("irq KCTRL", AKC, 32'h101);
        check("irq lag", {31'b0, irq}, 32'h0);
        tick(0);
        check("irq set", {31'b0, irq}, 32'h1);
        addr = AK; rdEn = 1'b1;
        tick(0);
        rdEn = 1'b0;
        check("irq after LW edge", {31'b0, irq}, 32'h1);
        tick(0);
        check("irq cleared", {31'b0, irq}, 32'h0);
`endif

        // Randomized run against the model
        key = 4'hF; sw = 10'h0;
        applyReset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) key = 4'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
            case ($urandom_range(0, 4))
                0:       addr = AK;
                1:       addr = AKC;
                2:       addr = AS;
                3:       addr = ASC;
                default: addr = $urandom;
            endcase
            rdEn  = ($urandom_range(0, 2) == 0);
            wrtEn = ($urandom_range(0, 5) == 0);
            dIn   = $urandom;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
